// File: rtl/tlc_phase_scheduler.sv
// Four-approach traffic phase sequencer (GREEN->YELLOW->ALL_RED, N,E,S,W) with tick-based dwell
// timing and fixed-priority emergency hold/pre-emption. Lamps and ack decode from registered state.
module tlc_phase_scheduler #(
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 30,
   parameter int MIN_GREEN    = 5,
   parameter int YELLOW_TICKS = 4,
   parameter int ALLRED_TICKS = 2,
   parameter int MAX_HOLD     = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] emerg_req,
   output logic [3:0] emerg_ack,
   output logic [1:0] phase,
   output logic [1:0] north_l,
   output logic [1:0] east_l,
   output logic [1:0] south_l,
   output logic [1:0] west_l
);

   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_t;

   localparam logic [1:0] LAMP_RED    = 2'd0;
   localparam logic [1:0] LAMP_YELLOW = 2'd1;
   localparam logic [1:0] LAMP_GREEN  = 2'd2;

   localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_TICKS);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_TICKS);
   localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_TICKS);
   localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(MAX_HOLD);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hold;
   logic             held_out;

   logic [3:0]       phase_bit;
   logic             own_req;
   logic             other_req;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] hold_inc;
   logic [3:0]       cand;
   logic             win_vld;
   logic [1:0]       win_phase;
   logic [1:0]       lamp_val;

   // Request bit 3 is north (phase 0), bit 0 is west (phase 3).
   assign phase_bit = 4'b1000 >> phase;
   assign own_req   = |(emerg_req & phase_bit);
   assign other_req = |(emerg_req & ~phase_bit);
   assign cnt_inc   = cnt + 1'b1;
   assign hold_inc  = hold + 1'b1;

   // A phase that just ran out its hold cannot immediately win itself back.
   assign cand    = emerg_req & ~(held_out ? phase_bit : 4'b0000);
   assign win_vld = |cand;

   always_comb begin
      win_phase = 2'd3;
      if (cand[3])      win_phase = 2'd0;
      else if (cand[2]) win_phase = 2'd1;
      else if (cand[1]) win_phase = 2'd2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_GREEN;
         phase    <= 2'd0;
         cnt      <= '0;
         hold     <= '0;
         held_out <= 1'b0;
      end else begin
         case (state)
            S_GREEN: begin
               if (own_req) begin
                  if (tick) begin
                     if (cnt < GREEN_C) begin
                        cnt <= cnt_inc;
                     end else if (hold_inc >= HOLD_C) begin
                        state    <= S_YELLOW;
                        cnt      <= '0;
                        hold     <= '0;
                        held_out <= 1'b1;
                     end else begin
                        hold <= hold_inc;
                     end
                  end
               end else if (other_req && (cnt >= MIN_C)) begin
                  // Pre-emption ignores a coincident tick: the new state starts at zero.
                  state <= S_YELLOW;
                  cnt   <= '0;
                  hold  <= '0;
               end else if (tick) begin
                  if (cnt_inc >= GREEN_C) begin
                     state <= S_YELLOW;
                     cnt   <= '0;
                     hold  <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            S_YELLOW: begin
               if (tick) begin
                  if (cnt_inc >= YELLOW_C) begin
                     state <= S_ALL_RED;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            S_ALL_RED: begin
               if (tick) begin
                  if (cnt_inc >= ALLRED_C) begin
                     state    <= S_GREEN;
                     cnt      <= '0;
                     held_out <= 1'b0;
                     phase    <= win_vld ? win_phase : 2'(phase + 2'd1);
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            default: begin
               state <= S_GREEN;
               cnt   <= '0;
               hold  <= '0;
            end
         endcase
      end
   end

   always_comb begin
      lamp_val = LAMP_RED;
      if (state == S_GREEN)       lamp_val = LAMP_GREEN;
      else if (state == S_YELLOW) lamp_val = LAMP_YELLOW;
   end

   always_comb begin
      north_l = LAMP_RED;
      east_l  = LAMP_RED;
      south_l = LAMP_RED;
      west_l  = LAMP_RED;
      case (phase)
         2'd0:    north_l = lamp_val;
         2'd1:    east_l  = lamp_val;
         2'd2:    south_l = lamp_val;
         default: west_l  = lamp_val;
      endcase
   end

   assign emerg_ack = (state == S_GREEN) ? (emerg_req & phase_bit) : 4'b0000;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: table of lamp-change records plus hand sequences for
// mid-green requests and asynchronous reset; expected changes are queued and popped on each change.
module tb_tlc_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] emerg_req;
   logic [3:0] emerg_ack;
   logic [1:0] phase;
   logic [1:0] north_l, east_l, south_l, west_l;

   localparam logic [1:0] R = 2'd0;
   localparam logic [1:0] Y = 2'd1;
   localparam logic [1:0] G = 2'd2;

   always #5 clk = ~clk;

   tlc_phase_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .emerg_req (emerg_req),
      .emerg_ack (emerg_ack),
      .phase     (phase),
      .north_l   (north_l),
      .east_l    (east_l),
      .south_l   (south_l),
      .west_l    (west_l)
   );

   typedef struct {
      logic       do_rst;
      logic [3:0] req;
      logic [1:0] ph;
      logic [7:0] lamps;
      logic [3:0] ack;
      int         ticks;
   } vec_t;

   vec_t       tbl[$];
   vec_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   int         ccount = 0;
   int         tick_acc = 0;
   int         ev_id = 0;
   logic [9:0] prev_obs;

   function automatic logic [7:0] lp(int ph, logic [1:0] v);
      logic [7:0] base;
      base = {v, 6'b0};
      return base >> (2 * ph);
   endfunction

   function automatic vec_t mk(logic r, logic [3:0] req, logic [1:0] ph, logic [7:0] lamps,
                               logic [3:0] ack, int ticks);
      vec_t v;
      v.do_rst = r; v.req = req; v.ph = ph; v.lamps = lamps; v.ack = ack; v.ticks = ticks;
      return v;
   endfunction

   function automatic logic [7:0] lamps_now();
      return {north_l, east_l, south_l, west_l};
   endfunction

   task automatic check_out(string nm, logic [1:0] ph, logic [7:0] lamps, logic [3:0] ack);
      tests++;
      if (phase !== ph || lamps_now() !== lamps || emerg_ack !== ack) begin
         fails++;
         $display("FAIL %s: got phase=%0d lamps=%h ack=%b, want phase=%0d lamps=%h ack=%b",
                  nm, phase, lamps_now(), emerg_ack, ph, lamps, ack);
      end
   endtask

   // One clock: drive tick on the falling edge, sample just after the rising edge.
   task automatic one_cycle();
      vec_t e;
      @(negedge clk);
      tick = (ccount % 4 == 0);
      ccount++;
      @(posedge clk);
      if (tick) tick_acc++;
      #1;
      if ({phase, lamps_now()} !== prev_obs) begin
         prev_obs = {phase, lamps_now()};
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: phase=%0d lamps=%h after %0d ticks",
                     phase, lamps_now(), tick_acc);
         end else begin
            e = sb.pop_front();
            ev_id++;
            if (phase !== e.ph || lamps_now() !== e.lamps || emerg_ack !== e.ack ||
                tick_acc != e.ticks) begin
               fails++;
               $display("FAIL event_%0d: got phase=%0d lamps=%h ack=%b ticks=%0d, want phase=%0d lamps=%h ack=%b ticks=%0d",
                        ev_id, phase, lamps_now(), emerg_ack, tick_acc,
                        e.ph, e.lamps, e.ack, e.ticks);
            end
         end
         tick_acc = 0;
      end
   endtask

   task automatic wait_events(int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         one_cycle();
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL event_timeout: %0d expected changes not seen in %0d cycles", sb.size(), budget);
         sb.delete();
      end
   endtask

   task automatic wait_ticks(int count, int budget);
      int n;
      n = 0;
      while (tick_acc < count && n < budget) begin
         one_cycle();
         n++;
      end
      if (tick_acc < count) begin
         tests++;
         fails++;
         $display("FAIL tick_timeout: got %0d ticks, want %0d", tick_acc, count);
      end
   endtask

   task automatic expect_ev(logic [1:0] ph, logic [7:0] lamps, logic [3:0] ack, int ticks);
      sb.push_back(mk(1'b0, 4'b0, ph, lamps, ack, ticks));
      wait_events(2000);
   endtask

   task automatic do_reset(logic [3:0] req);
      @(negedge clk);
      rst = 1'b1;
      tick = 1'b0;
      emerg_req = req;
      #1;
      check_out("reset_state", 2'd0, lp(0, G), req & 4'b1000);
      @(negedge clk);
      rst = 1'b0;
      ccount = 0;
      tick_acc = 0;
      sb.delete();
      prev_obs = {phase, lamps_now()};
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      emerg_req = 4'b0000;

      // Normal rotation, then a two-way request during N all-red.
      tbl.push_back(mk(1'b1, 4'b0000, 2'd0, lp(0, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd0, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd1, lp(1, G), 4'b0000, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd1, lp(1, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd1, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd2, lp(2, G), 4'b0000, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd2, lp(2, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd2, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd3, lp(3, G), 4'b0000, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd3, lp(3, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd3, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd0, lp(0, G), 4'b0000, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd0, lp(0, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd0, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0110, 2'd1, lp(1, G), 4'b0100, 2));
      tbl.push_back(mk(1'b0, 4'b0010, 2'd1, lp(1, Y), 4'b0000, 5));
      tbl.push_back(mk(1'b0, 4'b0010, 2'd1, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0010, 2'd2, lp(2, G), 4'b0010, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd2, lp(2, Y), 4'b0000, 30));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd2, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd3, lp(3, G), 4'b0000, 2));
      // North held from reset up to the hold limit, then excluded once.
      tbl.push_back(mk(1'b1, 4'b1000, 2'd0, lp(0, Y), 4'b0000, 90));
      tbl.push_back(mk(1'b0, 4'b1000, 2'd0, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b1000, 2'd1, lp(1, G), 4'b0000, 2));
      tbl.push_back(mk(1'b0, 4'b1000, 2'd1, lp(1, Y), 4'b0000, 5));
      tbl.push_back(mk(1'b0, 4'b1000, 2'd1, 8'h00,    4'b0000, 4));
      tbl.push_back(mk(1'b0, 4'b1000, 2'd0, lp(0, G), 4'b1000, 2));
      tbl.push_back(mk(1'b0, 4'b0000, 2'd0, lp(0, Y), 4'b0000, 30));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].do_rst) do_reset(tbl[i].req);
         emerg_req = tbl[i].req;
         sb.push_back(tbl[i]);
         wait_events(2000);
      end

      // South request arriving at N green tick 10 pre-empts on the next clock.
      do_reset(4'b0000);
      wait_ticks(10, 200);
      emerg_req = 4'b0010;
      expect_ev(2'd0, lp(0, Y), 4'b0000, 10);
      expect_ev(2'd0, 8'h00,    4'b0000, 4);
      expect_ev(2'd2, lp(2, G), 4'b0010, 2);
      emerg_req = 4'b0000;
      expect_ev(2'd2, lp(2, Y), 4'b0000, 30);

      // West request before minimum green is served waits until cnt reaches 5.
      do_reset(4'b0000);
      wait_ticks(2, 200);
      emerg_req = 4'b0001;
      expect_ev(2'd0, lp(0, Y), 4'b0000, 5);
      expect_ev(2'd0, 8'h00,    4'b0000, 4);
      expect_ev(2'd3, lp(3, G), 4'b0001, 2);
      emerg_req = 4'b0000;
      expect_ev(2'd3, lp(3, Y), 4'b0000, 30);

      // Asynchronous reset during E yellow, then a full-length N green afterwards.
      do_reset(4'b0000);
      expect_ev(2'd0, lp(0, Y), 4'b0000, 30);
      expect_ev(2'd0, 8'h00,    4'b0000, 4);
      expect_ev(2'd1, lp(1, G), 4'b0000, 2);
      expect_ev(2'd1, lp(1, Y), 4'b0000, 30);
      one_cycle();
      one_cycle();
      rst = 1'b1;
      #1;
      check_out("midcycle_reset", 2'd0, lp(0, G), 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      tick = 1'b0;
      ccount = 0;
      tick_acc = 0;
      prev_obs = {phase, lamps_now()};
      expect_ev(2'd0, lp(0, Y), 4'b0000, 30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
